// File: rtl/phy_rx_align_demux.sv
// phy_rx_align_demux
//   Serial-to-parallel receive path with comma-based word alignment and a
//   round-robin lane demultiplexer, clocked entirely by the serial bit clock.
//   SEARCH slides a window over the bit stream looking for COMMA. ALIGN
//   requires LOCK_CNT commas on consecutive word boundaries. LOCKED strips
//   boundary commas and deals data words over LANES outputs. Repeated
//   off-boundary commas drop the block back to SEARCH.
//
// Ports
//   clk_32f    in   serial bit clock, rising edge
//   reset      in   asynchronous active-low reset
//   data_in    in   serial data, MSB of each word first
//   data_out   out  LANES*WIDTH, lane i at [i*WIDTH +: WIDTH], holds last word
//   valid_out  out  LANES, one-cycle pulse on the lane just written
//   active     out  high while LOCKED
//   lane_ptr   out  next lane to be written

module phy_rx_align_demux #(
    parameter int unsigned       WIDTH        = 8,
    parameter logic [WIDTH-1:0]  COMMA        = 8'hBC,
    parameter int unsigned       LOCK_CNT     = 4,
    parameter int unsigned       MISALIGN_CNT = 2,
    parameter int unsigned       LANES        = 4,
    localparam int unsigned      PW           = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                   clk_32f,
    input  logic                   reset,
    input  logic                   data_in,
    output logic [LANES*WIDTH-1:0] data_out,
    output logic [LANES-1:0]       valid_out,
    output logic                   active,
    output logic [PW-1:0]          lane_ptr
);

    localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_ALIGN,
        ST_LOCKED
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [WIDTH-1:0]       r_sr;
    logic [BW-1:0]          r_bit_cnt, w_bit_cnt_nxt;
    logic [3:0]             r_comma_cnt, w_comma_cnt_nxt;
    logic [3:0]             r_mis_cnt, w_mis_cnt_nxt;
    logic [PW-1:0]          r_lane_ptr, w_lane_ptr_nxt;
    logic [LANES*WIDTH-1:0] r_data, w_data_nxt;
    logic [LANES-1:0]       r_valid, w_valid_nxt;

    logic [WIDTH-1:0]       w_word;
    logic                   w_is_comma;
    logic                   w_boundary;
    logic [3:0]             w_comma_inc;
    logic [3:0]             w_mis_inc;
    logic [PW-1:0]          w_ptr_adv;

    // Candidate word includes the bit sampled at this edge.
    assign w_word      = {r_sr[WIDTH-2:0], data_in};
    assign w_is_comma  = (w_word == COMMA);
    assign w_boundary  = (r_bit_cnt == BW'(WIDTH - 1));
    assign w_comma_inc = r_comma_cnt + 4'd1;
    assign w_mis_inc   = r_mis_cnt + 4'd1;
    assign w_ptr_adv   = (r_lane_ptr == PW'(LANES - 1)) ? '0 : r_lane_ptr + 1'b1;

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_SEARCH;
            r_sr        <= '0;
            r_bit_cnt   <= '0;
            r_comma_cnt <= '0;
            r_mis_cnt   <= '0;
            r_lane_ptr  <= '0;
            r_data      <= '0;
            r_valid     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sr        <= w_word;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_comma_cnt <= w_comma_cnt_nxt;
            r_mis_cnt   <= w_mis_cnt_nxt;
            r_lane_ptr  <= w_lane_ptr_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_bit_cnt_nxt   = w_boundary ? '0 : r_bit_cnt + 1'b1;
        w_comma_cnt_nxt = r_comma_cnt;
        w_mis_cnt_nxt   = r_mis_cnt;
        w_lane_ptr_nxt  = r_lane_ptr;
        w_data_nxt      = r_data;
        w_valid_nxt     = '0;

        unique case (r_state)
            ST_SEARCH: begin
                w_bit_cnt_nxt = r_bit_cnt;
                if (w_is_comma) begin
                    // This edge closes a word, so the counter restarts here.
                    w_bit_cnt_nxt   = '0;
                    w_comma_cnt_nxt = 4'd1;
                    if (LOCK_CNT == 1) begin
                        w_state_nxt    = ST_LOCKED;
                        w_lane_ptr_nxt = '0;
                        w_mis_cnt_nxt  = '0;
                    end else begin
                        w_state_nxt = ST_ALIGN;
                    end
                end
            end

            ST_ALIGN: begin
                if (w_boundary) begin
                    if (w_is_comma) begin
                        w_comma_cnt_nxt = w_comma_inc;
                        if (w_comma_inc >= 4'(LOCK_CNT)) begin
                            w_comma_cnt_nxt = 4'(LOCK_CNT);
                            w_state_nxt     = ST_LOCKED;
                            w_lane_ptr_nxt  = '0;
                            w_mis_cnt_nxt   = '0;
                        end
                    end else begin
                        w_state_nxt     = ST_SEARCH;
                        w_comma_cnt_nxt = '0;
                    end
                end
            end

            ST_LOCKED: begin
                if (w_boundary) begin
                    if (w_is_comma) begin
                        w_lane_ptr_nxt = '0;
                        w_mis_cnt_nxt  = '0;
                    end else begin
                        for (int unsigned i = 0; i < LANES; i++) begin
                            if (r_lane_ptr == PW'(i)) begin
                                w_data_nxt[i*WIDTH +: WIDTH] = w_word;
                                w_valid_nxt[i]               = 1'b1;
                            end
                        end
                        w_lane_ptr_nxt = w_ptr_adv;
                    end
                end else if (w_is_comma) begin
                    w_mis_cnt_nxt = w_mis_inc;
                    if (w_mis_inc >= 4'(MISALIGN_CNT)) begin
                        // Misalignment count is dropped with the lock so a
                        // later relock starts from a clean slate.
                        w_state_nxt     = ST_SEARCH;
                        w_lane_ptr_nxt  = '0;
                        w_comma_cnt_nxt = '0;
                        w_mis_cnt_nxt   = '0;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_SEARCH;
            end
        endcase
    end

    assign data_out  = r_data;
    assign valid_out = r_valid;
    assign active    = (r_state == ST_LOCKED);
    assign lane_ptr  = r_lane_ptr;

endmodule

// File: tb/tb_phy_rx_align_demux.sv
// tb_phy_rx_align_demux
//   Scoreboard bench: the driver feeds bits, steps a bit-level reference model
//   and pushes the expected post-edge outputs; a monitor on the falling edge
//   pops and compares them against the design.

module tb_phy_rx_align_demux;

    localparam int unsigned    WIDTH        = 8;
    localparam logic [7:0]     COMMA        = 8'hBC;
    localparam int unsigned    LOCK_CNT     = 4;
    localparam int unsigned    MISALIGN_CNT = 2;
    localparam int unsigned    LANES        = 4;
    localparam int unsigned    PW           = 2;

    logic                   clk_32f = 1'b0;
    logic                   reset   = 1'b0;
    logic                   data_in = 1'b0;
    logic [LANES*WIDTH-1:0] data_out;
    logic [LANES-1:0]       valid_out;
    logic                   active;
    logic [PW-1:0]          lane_ptr;

    int n_tests = 0;
    int n_fail  = 0;

    phy_rx_align_demux #(
        .WIDTH        (WIDTH),
        .COMMA        (COMMA),
        .LOCK_CNT     (LOCK_CNT),
        .MISALIGN_CNT (MISALIGN_CNT),
        .LANES        (LANES)
    ) dut (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active),
        .lane_ptr  (lane_ptr)
    );

    always #5 clk_32f = ~clk_32f;

    typedef struct {
        logic [LANES-1:0]       valid;
        logic                   act;
        logic [PW-1:0]          ptr;
        logic [LANES*WIDTH-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [63:0] act_v,
                         input logic [63:0] exp_v);
        n_tests++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act_v, exp_v);
        end
    endtask

    // ---------------- reference model ----------------
    // Modes: 0 hunting for a comma, 1 counting aligned commas, 2 locked.
    bit             m_hist[$];
    int             m_t, m_anchor, m_mode, m_commas, m_mis, m_ptr;
    logic [7:0]     m_lane[LANES];

    task automatic model_reset();
        m_hist.delete();
        m_t = 0; m_anchor = 0; m_mode = 0; m_commas = 0; m_mis = 0; m_ptr = 0;
        for (int i = 0; i < LANES; i++) m_lane[i] = 8'h00;
    endtask

    function automatic logic [7:0] model_word();
        logic [7:0] v;
        int         pad;
        v   = 8'h00;
        pad = WIDTH - m_hist.size();
        for (int k = 0; k < WIDTH; k++)
            v = {v[6:0], (k < pad) ? 1'b0 : m_hist[k - pad]};
        return v;
    endfunction

    task automatic model_step(input bit b);
        logic [7:0] w;
        bit         on_bnd;
        int         vl;
        exp_t       e;
        m_t++;
        m_hist.push_back(b);
        if (m_hist.size() > WIDTH) void'(m_hist.pop_front());
        w      = model_word();
        on_bnd = (m_t > m_anchor) && (((m_t - m_anchor) % WIDTH) == 0);
        vl     = -1;
        case (m_mode)
            0: if (w == COMMA) begin
                m_anchor = m_t;
                m_commas = 1;
                m_mode   = (LOCK_CNT == 1) ? 2 : 1;
                m_ptr    = 0;
                m_mis    = 0;
            end
            1: if (on_bnd) begin
                if (w == COMMA) begin
                    m_commas++;
                    if (m_commas == LOCK_CNT) begin m_mode = 2; m_ptr = 0; m_mis = 0; end
                end else begin
                    m_mode = 0; m_commas = 0;
                end
            end
            default: begin
                if (on_bnd) begin
                    if (w == COMMA) begin
                        m_ptr = 0; m_mis = 0;
                    end else begin
                        m_lane[m_ptr] = w;
                        vl            = m_ptr;
                        m_ptr         = (m_ptr + 1) % LANES;
                    end
                end else if (w == COMMA) begin
                    if (m_mis < MISALIGN_CNT) m_mis++;
                    if (m_mis == MISALIGN_CNT) begin
                        m_mode = 0; m_ptr = 0; m_commas = 0; m_mis = 0;
                    end
                end
            end
        endcase
        e.valid = '0;
        if (vl >= 0) e.valid[vl] = 1'b1;
        e.act = (m_mode == 2);
        e.ptr = PW'(m_ptr);
        for (int i = 0; i < LANES; i++) e.data[i*WIDTH +: WIDTH] = m_lane[i];
        exp_q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk_32f) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("valid_out", 64'(valid_out), 64'(mon_e.valid));
            check("active",    64'(active),    64'(mon_e.act));
            check("lane_ptr",  64'(lane_ptr),  64'(mon_e.ptr));
            check("data_out",  64'(data_out),  64'(mon_e.data));
        end else begin
            check("idle_valid", 64'(valid_out), 64'd0);
        end
    end

    // ---------------- driver ----------------
    task automatic send_bit(input bit b);
        data_in = b;
        @(posedge clk_32f);
        model_step(b);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w);
        logic [7:0] t;
        t = w;
        for (int k = WIDTH - 1; k >= 0; k--) send_bit(t[k]);
    endtask

    task automatic send_commas(input int n);
        for (int k = 0; k < n; k++) send_word(COMMA);
    endtask

    // Asserts reset between edges and checks the outputs clear without a clock.
    task automatic apply_reset();
        @(negedge clk_32f);
        #1;
        reset = 1'b0;
        #1;
        check("rst_active",    64'(active),    64'd0);
        check("rst_valid_out", 64'(valid_out), 64'd0);
        check("rst_data_out",  64'(data_out),  64'd0);
        check("rst_lane_ptr",  64'(lane_ptr),  64'd0);
        model_reset();
        repeat (3) @(posedge clk_32f);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [7:0] demux_seq[7];
        demux_seq = '{8'hFF, 8'h00, 8'hA5, 8'h3C, 8'h11, 8'hBC, 8'h22};

        apply_reset();
        repeat (64) send_bit(1'b0);

        // acquisition after junk bits
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        send_commas(4);
        check("acq_active", 64'(active), 64'd1);

        // demux with pointer reset on an idle comma
        foreach (demux_seq[i]) send_word(demux_seq[i]);

        // slip by one bit, lose lock, relock at the new offset
        send_bit(1'b0);
        send_commas(2);
        check("slip_active", 64'(active), 64'd0);
        send_commas(4);
        send_word(8'h5A); send_word(8'hC3);

        // failed lock then successful lock
        apply_reset();
        send_commas(3);
        send_word(8'h55);
        send_commas(4);
        send_word(8'h77); send_word(8'h88);

        // randomized traffic
        for (int r = 0; r < 40; r++) begin
            int nj, nw, p;
            nj = $urandom_range(0, 9);
            for (int k = 0; k < nj; k++) send_bit(1'($urandom_range(0, 1)));
            send_commas(4 + $urandom_range(0, 2));
            nw = $urandom_range(3, 12);
            for (int k = 0; k < nw; k++) begin
                p = $urandom_range(0, 99);
                if (p < 15)       send_word(COMMA);
                else if (p < 20)  repeat ($urandom_range(1, 3)) send_bit(1'($urandom_range(0, 1)));
                else              send_word(8'($urandom_range(0, 255)));
            end
        end

        // reset mid-word while locked with lane data present
        send_commas(4);
        send_word(8'h12); send_word(8'h34); send_word(8'h56);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        apply_reset();
        send_commas(3);
        send_word(8'h9A);
        send_commas(4);
        send_word(8'hDE); send_word(8'hAD);

        repeat (2) @(negedge clk_32f);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
